// File: rtl/slow_clk_monitor.sv
// Slow clock monitor: synchronises a divided clock into the clk_100MHz domain, emits
// single-cycle rise/fall pulses, measures each half period and reports lock/timeout.
module slow_clk_monitor #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned EXP_HALF_PERIOD = 50000,
  parameter int unsigned TOL             = 16,
  parameter int unsigned LOCK_COUNT      = 4,
  parameter int unsigned CNT_W           = 27
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             slow_clk_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             period_err,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CntMax      = '1;
  localparam logic [CNT_W-1:0] ExpHp       = CNT_W'(EXP_HALF_PERIOD);
  localparam logic [CNT_W-1:0] TolW        = CNT_W'(TOL);
  // Last counter value before the timeout threshold; interval = counter + 1.
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(2 * EXP_HALF_PERIOD - 1);
  localparam logic [GoodW-1:0] GoodMax     = GoodW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    StIdle,
    StAcq,
    StTrack,
    StLost
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       hp_q, hp_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [GoodW-1:0]       good_q, good_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;
  logic                   rise_q, fall_q;

  logic             sync_last;
  logic             rise_det;
  logic             fall_det;
  logic             edge_det;
  logic [CNT_W-1:0] interval;
  logic [CNT_W-1:0] diff;
  logic             in_tol;

  // Synchroniser chain, previous-level flop and registered edge pulses.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= rise_det;
      fall_q <= fall_det;
    end
  end

  // Edge detection and unsigned-safe tolerance check on the current interval.
  always_comb begin
    sync_last = sync_q[SYNC_STAGES-1];
    rise_det  = sync_last & ~prev_q;
    fall_det  = ~sync_last & prev_q;
    edge_det  = rise_det | fall_det;
    interval  = (cnt_q == CntMax) ? CntMax : cnt_q + CNT_W'(1);
    diff      = (interval >= ExpHp) ? (interval - ExpHp) : (ExpHp - interval);
    in_tol    = (diff <= TolW);
  end

  // State and measurement registers.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hp_q      <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      good_q    <= '0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: an edge always takes priority over the timeout threshold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
    hp_d      = hp_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    good_d    = good_q;
    locked_d  = locked_q;
    timeout_d = timeout_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (edge_det) begin
          state_d = StAcq;
        end
      end
      StAcq, StTrack: begin
        if (edge_det) begin
          cnt_d   = '0;
          state_d = StTrack;
          hp_d    = interval;
          valid_d = 1'b1;
          if (in_tol) begin
            good_d   = (good_q == GoodMax) ? good_q : good_q + GoodW'(1);
            locked_d = (good_d == GoodMax);
          end else begin
            err_d    = 1'b1;
            good_d   = '0;
            locked_d = 1'b0;
          end
        end else if (cnt_q >= TimeoutLast) begin
          state_d   = StLost;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          valid_d   = 1'b0;
          good_d    = '0;
        end
      end
      StLost: begin
        if (edge_det) begin
          cnt_d     = '0;
          state_d   = StAcq;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign half_period  = hp_q;
  assign period_valid = valid_q;
  assign period_err   = err_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Bench for slow_clk_monitor: timestamp-based reference model, per-cycle compare plus
// hand-computed literal checks.
module tb_slow_clk_monitor;

  localparam int SYNC  = 2;
  localparam int EXP   = 10;
  localparam int TOLR  = 1;
  localparam int LOCKN = 3;
  localparam int CW    = 8;

  logic          clk_100MHz;
  logic          reset;
  logic          slow_clk_in;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [CW-1:0] half_period;
  logic          period_valid;
  logic          period_err;
  logic          locked;
  logic          timeout;

  slow_clk_monitor #(
    .SYNC_STAGES    (SYNC),
    .EXP_HALF_PERIOD(EXP),
    .TOL            (TOLR),
    .LOCK_COUNT     (LOCKN),
    .CNT_W          (CW)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .slow_clk_in (slow_clk_in),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .half_period (half_period),
    .period_valid(period_valid),
    .period_err  (period_err),
    .locked      (locked),
    .timeout     (timeout)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  int n_vec;
  int n_err;

  // Reference model: input samples per clock edge, edge timestamps, mode 0..3 =
  // idle / acquiring / tracking / lost.
  int   m_t;
  int   m_last;
  int   m_mode;
  int   m_good;
  logic s_hist [0:3];
  int   e_rise, e_fall, e_hp, e_valid, e_err, e_locked, e_timeout;

  task automatic model_clear();
    m_t = 0; m_last = 0; m_mode = 0; m_good = 0;
    for (int i = 0; i < 4; i++) s_hist[i] = 1'b0;
    e_rise = 0; e_fall = 0; e_hp = 0; e_valid = 0; e_err = 0; e_locked = 0; e_timeout = 0;
  endtask

  // One clock edge of the model; a detected edge is a level change seen SYNC+1 edges late.
  task automatic model_tick();
    bit ed;
    int iv;
    if (reset) begin
      model_clear();
    end else begin
      m_t++;
      for (int i = 3; i > 0; i--) s_hist[i] = s_hist[i-1];
      s_hist[0] = slow_clk_in;
      ed     = (s_hist[SYNC] != s_hist[SYNC+1]);
      e_rise = (ed && s_hist[SYNC]) ? 1 : 0;
      e_fall = (ed && !s_hist[SYNC]) ? 1 : 0;
      e_err  = 0;
      if (ed) begin
        if (m_mode == 1 || m_mode == 2) begin
          iv      = m_t - m_last;
          e_hp    = iv;
          e_valid = 1;
          if (iv >= EXP - TOLR && iv <= EXP + TOLR) begin
            if (m_good < LOCKN) m_good++;
            e_locked = (m_good == LOCKN) ? 1 : 0;
          end else begin
            e_err    = 1;
            m_good   = 0;
            e_locked = 0;
          end
          m_mode = 2;
        end else begin
          if (m_mode == 3) e_timeout = 0;
          m_mode = 1;
        end
        m_last = m_t;
      end else if ((m_mode == 1 || m_mode == 2) && (m_t - m_last == 2 * EXP)) begin
        m_mode    = 3;
        e_timeout = 1;
        e_locked  = 0;
        e_valid   = 0;
        m_good    = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    chk("rise_pulse", 32'(rise_pulse), 32'(e_rise));
    chk("fall_pulse", 32'(fall_pulse), 32'(e_fall));
    chk("half_period", 32'(half_period), 32'(e_hp));
    chk("period_valid", 32'(period_valid), 32'(e_valid));
    chk("period_err", 32'(period_err), 32'(e_err));
    chk("locked", 32'(locked), 32'(e_locked));
    chk("timeout", 32'(timeout), 32'(e_timeout));
    chk("pulse_overlap", 32'(rise_pulse & fall_pulse), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rise"}, 32'(rise_pulse), 32'd0);
    chk({tag, "_fall"}, 32'(fall_pulse), 32'd0);
    chk({tag, "_hp"}, 32'(half_period), 32'd0);
    chk({tag, "_valid"}, 32'(period_valid), 32'd0);
    chk({tag, "_err"}, 32'(period_err), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  // Advance one cycle: model follows the active edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk_100MHz);
    model_tick();
    @(negedge clk_100MHz);
    compare();
  endtask

  task automatic half(input int n);
    slow_clk_in = ~slow_clk_in;
    repeat (n) step();
  endtask

  initial begin
    int r;
    int h;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    slow_clk_in = 1'b0;
    model_clear();

    // Reset held while the input toggles: nothing may come out.
    repeat (12) begin
      step();
      slow_clk_in = ~slow_clk_in;
    end
    step();
    chk_all_zero("in_reset");
    slow_clk_in = 1'b0;
    step();
    reset = 1'b0;

    // Pulse latency: registered after the third sampling edge, one cycle wide.
    slow_clk_in = 1'b1;
    step();
    step();
    chk("lat_before", 32'(rise_pulse), 32'd0);
    step();
    chk("lat_rise", 32'(rise_pulse), 32'd1);
    chk("lat_fall", 32'(fall_pulse), 32'd0);
    step();
    chk("lat_width", 32'(rise_pulse), 32'd0);
    repeat (6) step();

    // Nominal square wave up to lock.
    repeat (7) half(10);
    chk("nom_hp", 32'(half_period), 32'd10);
    chk("nom_valid", 32'(period_valid), 32'd1);
    chk("nom_locked", 32'(locked), 32'd1);

    // Tolerance bounds.
    half(9); half(11); half(9); half(11);
    chk("tol_locked", 32'(locked), 32'd1);
    half(8); half(10);
    chk("low_unlock", 32'(locked), 32'd0);
    repeat (4) half(10);
    half(12); half(10);
    chk("high_unlock", 32'(locked), 32'd0);
    repeat (4) half(10);
    chk("relock", 32'(locked), 32'd1);

    // Stop toggling -> timeout, then recover.
    repeat (25) step();
    chk("to_timeout", 32'(timeout), 32'd1);
    chk("to_locked", 32'(locked), 32'd0);
    chk("to_valid", 32'(period_valid), 32'd0);
    repeat (5) half(10);

    // Edge coincides with the timeout threshold: edge wins.
    repeat (3) half(10);
    half(20);
    slow_clk_in = ~slow_clk_in;
    repeat (3) step();
    chk("thr_hp", 32'(half_period), 32'd20);
    chk("thr_err", 32'(period_err), 32'd1);
    chk("thr_timeout", 32'(timeout), 32'd0);
    repeat (7) step();

    // Asynchronous reset in the middle of a cycle while tracking.
    repeat (4) half(10);
    @(posedge clk_100MHz);
    model_tick();
    #2 reset = 1'b1;
    model_clear();
    #1 chk_all_zero("async_rst");
    @(negedge clk_100MHz);
    compare();
    step();
    reset = 1'b0;
    repeat (5) step();
    chk("post_rst_valid", 32'(period_valid), 32'd0);
    chk("post_rst_hp", 32'(half_period), 32'd0);

    // Randomised half periods around nominal, at the bounds, short and past timeout.
    repeat (80) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      h = 9 + int'($urandom_range(0, 2));
      else if (r == 6) h = ($urandom_range(0, 1) == 0) ? 8 : 12;
      else if (r == 7) h = int'($urandom_range(1, 24));
      else if (r == 8) h = int'($urandom_range(18, 30));
      else             h = 20;
      half(h);
    end
    repeat (30) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
